dekatron_counter: RTL and testbench
===================================

Name: dekatron_counter

Overview:
Multi-digit ring counter built from one-hot "tube" digits. Each digit is a 10-bit one-hot ring with a parametrised radix of 2..10, which covers both the decimal and octal tube styles. Increment and decrement ripple the carry one digit per clock, as a physical carry chain would. Loads and clears complete in one cycle. A Request/Ready/Done handshake lets the sequencer issue operations to the data-pointer and instruction-pointer register files.

Parameters:
DIGITS, 3, number of one-hot digits (1..8); digit 0 is least significant.
RADIX, 10, positions used per digit (2..10); bits [9:RADIX] of every digit are always 0.

Ports:
Clk  input  1  system clock; all state changes on its rising edge.
Rst_n  input  1  asynchronous, active-low reset.
Request  input  1  operation request; sampled only when Ready=1.
Op  input  2  00 increment, 01 decrement, 10 load In, 11 clear.
In  input  DIGITS*10  load value, 10 bits per digit, digit i at [10*i+9:10*i].
Ready  output  1  high in IDLE; the block accepts Request.
Done  output  1  one-cycle pulse when an operation completes.
Carry  output  1  one-cycle pulse with Done: overflow (inc) or underflow (dec) out of the top digit.
LoadErr  output  1  one-cycle pulse with Done: at least one loaded digit was invalid.
Zero  output  1  all digits at position 0; combinational from the digit registers.
Out  output  DIGITS*10  current one-hot digits, same packing as In.

Behaviour:
- Reset (async, Rst_n=0):
  - every digit = 10'b0000000001; state IDLE; Ready=1.
  - Done=Carry=LoadErr=0; Zero=1.
  - Reset asserted mid-ripple aborts the operation; no Done is produced.
- States:
  - IDLE: Ready=1. On an edge with Request=1, latch Op.
    - Op=inc/dec: go to RIPPLE with idx=0; Out unchanged on this edge.
    - Op=load: write all digits on this edge and stay IDLE. Done is high for the following cycle.
    - Op=clear: set all digits to position 0 on this edge and stay IDLE. Done is high for the following cycle.
  - RIPPLE: Ready=0. Each edge steps digit idx.
    - Increment: position p -> p+1, with wrap from position RADIX-1 to 0.
    - Decrement: position p -> p-1, with wrap from 0 to RADIX-1.
    - If the step wrapped and idx<DIGITS-1: idx <= idx+1 and stay in RIPPLE.
    - Otherwise go to IDLE, pulse Done, and pulse Carry if the top digit wrapped.
- Latency:
  - inc/dec touching k digits: Done is high k+1 cycles after the accepting edge (range 2..DIGITS+1).
  - load/clear: Done is high in the cycle after the accepting edge.
  - Ready returns in the same cycle Done is high. Back-to-back requests are accepted on that edge.
- Request with Ready=0 is ignored; it is neither queued nor does it alter the current operation.
- Load validation, per digit:
  - Valid means exactly one bit set, and that bit is within [RADIX-1:0].
  - An invalid digit loads as position 0 and sets LoadErr for that operation.
  - Valid digits load unchanged.
- Out only ever holds valid one-hot digits. An illegal internal pattern is impossible by construction; the bench asserts this every cycle.
- Done, Carry and LoadErr are registered and never high outside the Done cycle.
- Intermediate Out values during RIPPLE are visible, e.g. 199->190->100->200 for an increment.
- Zero updates combinationally with Out.
  - Zero is high after an inc that wrapped to all-zero, together with Carry.
- DIGITS=1: RIPPLE always lasts exactly one cycle.

Decomposition:
- Package dekatron_pkg holds:
  - DIGIT_W=10.
  - Op encodings OP_INC, OP_DEC, OP_LOAD, OP_CLR.
  - State enum {IDLE, RIPPLE}.
  - Function onehot_valid(digit, radix).
- Sub-module dekatron_digit (one instance per digit):
  - Inputs: Clk, Rst_n, step enable, direction, load enable, load value.
  - Outputs: one-hot position and a combinational wrap flag (a step at this cycle would wrap).
  - Radix wrap logic lives in this sub-module.
- The top level holds the FSM, idx counter, load validation and the output pulses.

Test Plan:
1. DIGITS=3, RADIX=10: load 199, then inc -> Out steps 190, 100, 200 on consecutive edges; Done 4 cycles after accept; Carry=0; Zero=0.
2. Load 999, inc -> Out=000, Carry=1 and Zero=1 with Done. Then dec from 000 -> 999, Carry=1, latency 4 cycles.
3. RADIX=8: load octal 077 (digit bit 7), inc -> 100; no digit ever has bit 8 or 9 set; Carry=0.
4. Load In with digit1=10'b0000000101 and digit2=10'b1000000000 under RADIX=8 -> both load as position 0; LoadErr=1; digit0 unchanged from In.
5. Load 099, inc; pulse Rst_n low during the second RIPPLE cycle -> Out=000 immediately; no Done; Ready=1 after release.
6. Hold Request=1 with alternating Op during the ripple of 999+1 -> intermediate requests are ignored; the next op is accepted on the Done edge and completes normally.

Source files
------------

// File: rtl/dekatron_pkg.sv
// -----------------------------------------------------------------------------
// dekatron_pkg
// Shared definitions for the dekatron ring counter: digit width, operation
// encodings, FSM state type and the one-hot digit validity check used when
// loading external values.
// -----------------------------------------------------------------------------
package dekatron_pkg;

  // Every digit is a 10-position one-hot ring regardless of radix.
  localparam int DIGIT_W = 10;

  // Operation encodings carried on Op.
  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Position 0 of a digit.
  localparam logic [DIGIT_W-1:0] POS0 = DIGIT_W'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    RIPPLE = 1'b1
  } state_e;

  // A digit is valid when exactly one bit is set and that bit lies inside the
  // positions used by the radix.
  function automatic logic onehot_valid(input logic [DIGIT_W-1:0] digit,
                                        input int                 radix);
    int   ones;
    logic in_range;
    ones     = 0;
    in_range = 1'b1;
    for (int b = 0; b < DIGIT_W; b++) begin
      if (digit[b]) begin
        ones++;
        if (b >= radix) in_range = 1'b0;
      end
    end
    return (ones == 1) && in_range;
  endfunction

endpackage

// File: rtl/dekatron_if.sv
// -----------------------------------------------------------------------------
// dekatron_if
// Request/Ready/Done handshake plus data buses between the sequencer and a
// dekatron_counter.
//   Request, Op, In               : sequencer -> counter
//   Ready, Done, Carry, LoadErr,
//   Zero, Out                     : counter -> sequencer
// Digit i occupies In/Out[10*i+9:10*i]; digit 0 is least significant.
// -----------------------------------------------------------------------------
interface dekatron_if #(
  parameter int DIGITS = 3
) ();
  import dekatron_pkg::*;

  logic                        Request;
  logic [1:0]                  Op;
  logic [DIGITS*DIGIT_W-1:0]   In;
  logic                        Ready;
  logic                        Done;
  logic                        Carry;
  logic                        LoadErr;
  logic                        Zero;
  logic [DIGITS*DIGIT_W-1:0]   Out;

  modport master (
    output Request, Op, In,
    input  Ready, Done, Carry, LoadErr, Zero, Out
  );

  modport slave (
    input  Request, Op, In,
    output Ready, Done, Carry, LoadErr, Zero, Out
  );

endinterface

// File: rtl/dekatron_digit.sv
// -----------------------------------------------------------------------------
// dekatron_digit
// One one-hot "tube" digit. Steps up or down by one position with wrap inside
// the radix, or loads a value that the parent has already validated.
//   Clk, Rst_n : clock, asynchronous active-low reset (digit -> position 0)
//   step_en    : move one position this edge
//   step_down  : direction of the step (1 = decrement)
//   load_en    : overwrite with load_val this edge (wins over step_en)
//   load_val   : valid one-hot value to load
//   pos        : current one-hot position
//   wrap       : a step in the current direction would wrap (combinational)
// -----------------------------------------------------------------------------
module dekatron_digit
  import dekatron_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               step_en,
  input  logic               step_down,
  input  logic               load_en,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] pos,
  output logic               wrap
);

  // Highest position used by this radix.
  localparam logic [DIGIT_W-1:0] POS_TOP = DIGIT_W'(1) << (RADIX - 1);

  logic [DIGIT_W-1:0] pos_nxt;

  // Upward the ring wraps out of the top used position, downward out of 0.
  assign wrap = step_down ? pos[0] : pos[RADIX-1];

  always_comb begin
    pos_nxt = pos;
    if (load_en) begin
      pos_nxt = load_val;
    end else if (step_en) begin
      if (step_down) pos_nxt = wrap ? POS_TOP : (pos >> 1);
      else           pos_nxt = wrap ? POS0    : (pos << 1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) pos <= POS0;
    else        pos <= pos_nxt;
  end

endmodule

// File: rtl/dekatron_counter.sv
// -----------------------------------------------------------------------------
// dekatron_counter
// Multi-digit one-hot ring counter. Increment/decrement ripple the carry one
// digit per clock; load and clear finish in a single edge.
//   Clk    : system clock
//   Rst_n  : asynchronous active-low reset (all digits to 0, FSM to IDLE,
//            aborts any ripple in progress without a Done)
//   bus    : dekatron_if slave port (Request/Op/In in; Ready, Done, Carry,
//            LoadErr, Zero, Out out)
// Parameters: DIGITS (1..8) digits, RADIX (2..10) positions per digit.
// -----------------------------------------------------------------------------
module dekatron_counter
  import dekatron_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int RADIX  = 10
) (
  input logic       Clk,
  input logic       Rst_n,
  dekatron_if.slave bus
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic                      dir_q, dir_nxt;
  logic                      done_q, done_nxt;
  logic                      carry_q, carry_nxt;
  logic                      lerr_q, lerr_nxt;

  logic [DIGITS-1:0]         step_en;
  logic [DIGITS-1:0]         wrap;
  logic                      sel_wrap;
  logic                      load_en;
  logic [DIGITS*DIGIT_W-1:0] load_val;
  logic [DIGITS*DIGIT_W-1:0] load_chk;
  logic                      load_bad;
  logic [DIGITS*DIGIT_W-1:0] pos_all;
  logic                      zero;

  // Sanitised load value: any invalid digit is replaced by position 0 so the
  // registers never hold an illegal pattern.
  always_comb begin
    load_chk = '0;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (onehot_valid(bus.In[i*DIGIT_W +: DIGIT_W], RADIX)) begin
        load_chk[i*DIGIT_W +: DIGIT_W] = bus.In[i*DIGIT_W +: DIGIT_W];
      end else begin
        load_chk[i*DIGIT_W +: DIGIT_W] = POS0;
        load_bad = 1'b1;
      end
    end
  end

  // Wrap flag of the digit currently being stepped.
  always_comb begin
    sel_wrap = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) sel_wrap = wrap[i];
    end
  end

  // Only the digit at idx moves, and only while rippling.
  always_comb begin
    step_en = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step_en[i] = (state == RIPPLE) && (idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dir_nxt   = dir_q;
    done_nxt  = 1'b0;
    carry_nxt = 1'b0;
    lerr_nxt  = 1'b0;
    load_en   = 1'b0;
    load_val  = load_chk;

    case (state)
      IDLE: begin
        if (bus.Request) begin
          case (bus.Op)
            OP_INC, OP_DEC: begin
              state_nxt = RIPPLE;
              idx_nxt   = '0;
              dir_nxt   = (bus.Op == OP_DEC);
            end
            OP_LOAD: begin
              load_en  = 1'b1;
              done_nxt = 1'b1;
              lerr_nxt = load_bad;
            end
            default: begin
              load_en  = 1'b1;
              load_val = {DIGITS{POS0}};
              done_nxt = 1'b1;
            end
          endcase
        end
      end

      RIPPLE: begin
        // Carry continues only while the stepped digit wraps and a higher
        // digit exists; a wrap of the top digit is the overflow/underflow.
        if (sel_wrap && (idx != IDX_LAST)) begin
          idx_nxt = idx + IDX_W'(1);
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          carry_nxt = sel_wrap;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      dir_q   <= dir_nxt;
      done_q  <= done_nxt;
      carry_q <= carry_nxt;
      lerr_q  <= lerr_nxt;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    dekatron_digit #(
      .RADIX(RADIX)
    ) u_digit (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .step_en  (step_en[g]),
      .step_down(dir_q),
      .load_en  (load_en),
      .load_val (load_val[g*DIGIT_W +: DIGIT_W]),
      .pos      (pos_all[g*DIGIT_W +: DIGIT_W]),
      .wrap     (wrap[g])
    );
  end

  always_comb begin
    zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos_all[i*DIGIT_W +: DIGIT_W] != POS0) zero = 1'b0;
    end
  end

  assign bus.Ready   = (state == IDLE);
  assign bus.Done    = done_q;
  assign bus.Carry   = carry_q;
  assign bus.LoadErr = lerr_q;
  assign bus.Zero    = zero;
  assign bus.Out     = pos_all;

endmodule

// File: tb/tb_dekatron_counter.sv
// -----------------------------------------------------------------------------
// tb_dekatron_counter
// Drives a decimal (RADIX=10) and an octal (RADIX=8) three-digit counter.
// A value-level model tracks each counter as an integer and derives the
// expected one-hot outputs every cycle; directed literals pin the model.
// -----------------------------------------------------------------------------
module tb_dekatron_counter;

  localparam int         N    = 3;
  localparam int         W    = 30;
  localparam logic [1:0] INC  = 2'b00;
  localparam logic [1:0] DEC  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  logic clk    = 1'b0;
  logic rst_n0 = 1'b0;
  logic rst_n1 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dekatron_if #(.DIGITS(N)) if0 ();
  dekatron_if #(.DIGITS(N)) if1 ();

  dekatron_counter #(.DIGITS(N), .RADIX(10)) u_dec (
    .Clk  (clk),
    .Rst_n(rst_n0),
    .bus  (if0.slave)
  );

  dekatron_counter #(.DIGITS(N), .RADIX(8)) u_oct (
    .Clk  (clk),
    .Rst_n(rst_n1),
    .bus  (if1.slave)
  );

  always #5 clk = ~clk;

  // ---------------- model state (index 0 = decimal, 1 = octal) -------------
  int rdx     [2] = '{10, 8};
  int m_val   [2] = '{0, 0};
  int m_start [2] = '{0, 0};
  int m_k     [2] = '{0, 0};
  int m_j     [2] = '{0, 0};
  bit m_busy  [2] = '{0, 0};
  bit m_dir   [2] = '{0, 0};
  bit e_done  [2] = '{0, 0};
  bit e_carry [2] = '{0, 0};
  bit e_lerr  [2] = '{0, 0};

  function automatic int pw(input int r, input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * r;
    return p;
  endfunction

  function automatic logic [W-1:0] enc(input int r, input int v);
    logic [W-1:0] o = '0;
    int           t = v;
    for (int i = 0; i < N; i++) begin
      o[10*i + (t % r)] = 1'b1;
      t = t / r;
    end
    return o;
  endfunction

  function automatic logic [W-1:0] oh3(input int p2, input int p1, input int p0);
    logic [W-1:0] o = '0;
    o[p0]      = 1'b1;
    o[10 + p1] = 1'b1;
    o[20 + p2] = 1'b1;
    return o;
  endfunction

  task automatic model_step(input int d, input logic rn, input logic req,
                            input logic [1:0] op, input logic [W-1:0] in);
    int r, full, t, val, pos;
    bit err;
    logic [9:0] s;
    r    = rdx[d];
    full = pw(r, N);
    e_done[d]  = 0;
    e_carry[d] = 0;
    e_lerr[d]  = 0;
    if (!rn) begin
      m_val[d]  = 0;
      m_busy[d] = 0;
    end else if (m_busy[d]) begin
      m_j[d]++;
      if (m_j[d] == m_k[d]) begin
        m_busy[d] = 0;
        e_done[d] = 1;
        if (!m_dir[d]) begin
          m_val[d]   = (m_start[d] + 1) % full;
          e_carry[d] = (m_start[d] == full - 1);
        end else begin
          m_val[d]   = (m_start[d] + full - 1) % full;
          e_carry[d] = (m_start[d] == 0);
        end
      end else if (!m_dir[d]) begin
        // lowest j digits have rolled over from r-1 to 0
        m_val[d] = (m_start[d] / pw(r, m_j[d])) * pw(r, m_j[d]);
      end else begin
        // lowest j digits have rolled under from 0 to r-1
        m_val[d] = m_start[d] + pw(r, m_j[d]) - 1;
      end
    end else if (req) begin
      case (op)
        INC, DEC: begin
          m_busy[d]  = 1;
          m_j[d]     = 0;
          m_start[d] = m_val[d];
          m_dir[d]   = (op == DEC);
          m_k[d]     = 1;
          t          = m_val[d];
          while (m_k[d] < N && (t % r) == (m_dir[d] ? 0 : r - 1)) begin
            m_k[d]++;
            t = t / r;
          end
        end
        LOAD: begin
          val = 0;
          err = 0;
          for (int i = 0; i < N; i++) begin
            s   = in[10*i +: 10];
            pos = 0;
            if ($countones(s) == 1 && (s >> r) == 0) begin
              for (int b = 0; b < 10; b++) if (s[b]) pos = b;
            end else begin
              err = 1;
            end
            val = val + pos * pw(r, i);
          end
          m_val[d]  = val;
          e_done[d] = 1;
          e_lerr[d] = err;
        end
        default: begin
          m_val[d]  = 0;
          e_done[d] = 1;
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n0);
    model_step(0, rst_n0, if0.Request, if0.Op, if0.In);
  end

  initial forever begin
    @(posedge clk or negedge rst_n1);
    model_step(1, rst_n1, if1.Request, if1.Op, if1.In);
  end

  // ---------------- DUT access helpers ----------------
  function automatic logic [W-1:0] out_of(input int d);
    return (d == 0) ? if0.Out : if1.Out;
  endfunction
  function automatic logic ready_of(input int d);
    return (d == 0) ? if0.Ready : if1.Ready;
  endfunction
  function automatic logic done_of(input int d);
    return (d == 0) ? if0.Done : if1.Done;
  endfunction
  function automatic logic carry_of(input int d);
    return (d == 0) ? if0.Carry : if1.Carry;
  endfunction
  function automatic logic lerr_of(input int d);
    return (d == 0) ? if0.LoadErr : if1.LoadErr;
  endfunction
  function automatic logic zero_of(input int d);
    return (d == 0) ? if0.Zero : if1.Zero;
  endfunction

  task automatic set_req(input int d, input logic r, input logic [1:0] op,
                         input logic [W-1:0] in);
    if (d == 0) begin
      if0.Request = r; if0.Op = op; if0.In = in;
    end else begin
      if1.Request = r; if1.Op = op; if1.In = in;
    end
  endtask

  task automatic chk_v(input string name, input int d, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %h, expected %h", name, d, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %b, expected %b", name, d, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %0d, expected %0d", name, d, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  task automatic compare_dut(input int d);
    logic [W-1:0] o;
    logic [9:0]   s;
    o = out_of(d);
    chk_v("out",     d, o,           enc(rdx[d], m_val[d]));
    chk_b("ready",   d, ready_of(d), !m_busy[d]);
    chk_b("done",    d, done_of(d),  e_done[d]);
    chk_b("carry",   d, carry_of(d), e_carry[d]);
    chk_b("loaderr", d, lerr_of(d),  e_lerr[d]);
    chk_b("zero",    d, zero_of(d),  m_val[d] == 0);
    for (int i = 0; i < N; i++) begin
      s = o[10*i +: 10];
      chk_b("onehot", d, ($countones(s) == 1) && ((s >> rdx[d]) == 0), 1'b1);
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare_dut(0);
    compare_dut(1);
  end

  // ---------------- stimulus helpers (entered just after a negedge) --------
  task automatic wait_ready(input int d);
    int n = 0;
    while (!ready_of(d) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_of(d)) chk_b("ready_timeout", d, 1'b0, 1'b1);
  endtask

  task automatic run_op(input int d, input logic [1:0] op, input logic [W-1:0] in,
                        input int exp_lat, input logic [W-1:0] exp_out,
                        input logic exp_c, input logic exp_e);
    int lat;
    bit seen;
    wait_ready(d);
    set_req(d, 1'b1, op, in);
    @(posedge clk);
    @(negedge clk);
    set_req(d, 1'b0, op, in);
    lat  = 1;
    seen = done_of(d);
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      seen = done_of(d);
    end
    chk_b("done_seen", d, seen, 1'b1);
    chk_i("latency",   d, lat, exp_lat);
    chk_v("result",    d, out_of(d), exp_out);
    chk_b("op_carry",  d, carry_of(d), exp_c);
    chk_b("op_lerr",   d, lerr_of(d), exp_e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] seq [4];
    logic [W-1:0] v;
    int  lat, dn;
    bit  seen;

    set_req(0, 1'b0, INC, '0);
    set_req(1, 1'b0, INC, '0);
    repeat (2) @(negedge clk);
    #2;
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk_v("rst_out",   d, out_of(d), oh3(0, 0, 0));
      chk_b("rst_ready", d, ready_of(d), 1'b1);
      chk_b("rst_done",  d, done_of(d), 1'b0);
      chk_b("rst_carry", d, carry_of(d), 1'b0);
      chk_b("rst_lerr",  d, lerr_of(d), 1'b0);
      chk_b("rst_zero",  d, zero_of(d), 1'b1);
    end

    // 199 + 1 with visible intermediate values
    run_op(0, LOAD, oh3(1, 9, 9), 1, oh3(1, 9, 9), 1'b0, 1'b0);
    seq[0] = oh3(1, 9, 9);
    seq[1] = oh3(1, 9, 0);
    seq[2] = oh3(1, 0, 0);
    seq[3] = oh3(2, 0, 0);
    wait_ready(0);
    set_req(0, 1'b1, INC, '0);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, INC, '0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk_v("t1_step", 0, out_of(0), seq[c]);
      chk_b("t1_done", 0, done_of(0), c == 3);
    end
    chk_b("t1_carry", 0, carry_of(0), 1'b0);
    chk_b("t1_zero",  0, zero_of(0), 1'b0);

    // overflow and underflow of the whole counter
    run_op(0, LOAD, oh3(9, 9, 9), 1, oh3(9, 9, 9), 1'b0, 1'b0);
    run_op(0, INC,  '0,           4, oh3(0, 0, 0), 1'b1, 1'b0);
    chk_b("t2_zero", 0, zero_of(0), 1'b1);
    run_op(0, DEC,  '0,           4, oh3(9, 9, 9), 1'b1, 1'b0);
    run_op(0, CLR,  '0,           1, oh3(0, 0, 0), 1'b0, 1'b0);
    run_op(0, LOAD, oh3(1, 2, 3), 1, oh3(1, 2, 3), 1'b0, 1'b0);
    run_op(0, INC,  '0,           2, oh3(1, 2, 4), 1'b0, 1'b0);
    run_op(0, LOAD, oh3(1, 2, 0), 1, oh3(1, 2, 0), 1'b0, 1'b0);
    run_op(0, DEC,  '0,           3, oh3(1, 1, 9), 1'b0, 1'b0);
    v    = oh3(4, 5, 0);
    v[0] = 1'b0;
    run_op(0, LOAD, v,            1, oh3(4, 5, 0), 1'b0, 1'b1);

    // octal counter: 077 + 1, invalid loads, wrap both ways
    run_op(1, LOAD, oh3(0, 7, 7), 1, oh3(0, 7, 7), 1'b0, 1'b0);
    run_op(1, INC,  '0,           4, oh3(1, 0, 0), 1'b0, 1'b0);
    v = {10'b1000000000, 10'b0000000101, 10'b0000001000};
    run_op(1, LOAD, v,            1, oh3(0, 0, 3), 1'b0, 1'b1);
    run_op(1, DEC,  '0,           2, oh3(0, 0, 2), 1'b0, 1'b0);
    run_op(1, CLR,  '0,           1, oh3(0, 0, 0), 1'b0, 1'b0);
    run_op(1, DEC,  '0,           4, oh3(7, 7, 7), 1'b1, 1'b0);
    run_op(1, INC,  '0,           4, oh3(0, 0, 0), 1'b1, 1'b0);

    // reset during the second ripple cycle of 099 + 1
    run_op(0, LOAD, oh3(0, 9, 9), 1, oh3(0, 9, 9), 1'b0, 1'b0);
    wait_ready(0);
    set_req(0, 1'b1, INC, '0);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, INC, '0);
    chk_v("t5_ripple1", 0, out_of(0), oh3(0, 9, 9));
    @(negedge clk);
    chk_v("t5_ripple2", 0, out_of(0), oh3(0, 9, 0));
    #2;
    rst_n0 = 1'b0;
    #1;
    chk_v("t5_rst_out",   0, out_of(0), oh3(0, 0, 0));
    chk_b("t5_rst_ready", 0, ready_of(0), 1'b1);
    chk_b("t5_rst_done",  0, done_of(0), 1'b0);
    chk_b("t5_rst_zero",  0, zero_of(0), 1'b1);
    @(negedge clk);
    #2;
    rst_n0 = 1'b1;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_of(0)) dn++;
    end
    chk_i("t5_no_done", 0, dn, 0);
    chk_b("t5_ready",   0, ready_of(0), 1'b1);

    // Request held with changing Op during 999 + 1; next op on the Done edge
    run_op(0, LOAD, oh3(9, 9, 9), 1, oh3(9, 9, 9), 1'b0, 1'b0);
    wait_ready(0);
    set_req(0, 1'b1, INC, '0);
    @(posedge clk);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (done_of(0)) seen = 1;
      else set_req(0, 1'b1, (lat % 2 == 1) ? CLR : LOAD, oh3(5, 5, 5));
    end
    chk_b("t6_done_seen", 0, seen, 1'b1);
    chk_i("t6_latency",   0, lat, 4);
    chk_v("t6_result",    0, out_of(0), oh3(0, 0, 0));
    chk_b("t6_carry",     0, carry_of(0), 1'b1);
    set_req(0, 1'b1, LOAD, oh3(1, 2, 3));
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, LOAD, '0);
    chk_b("t6_next_done", 0, done_of(0), 1'b1);
    chk_v("t6_next_out",  0, out_of(0), oh3(1, 2, 3));
    chk_b("t6_next_lerr", 0, lerr_of(0), 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
